// File: rtl/timer_sequencer.sv
// Avalon-MM master that programs, runs and tears down one interval timer
// (16-bit register map) on behalf of a single timing command.
module timer_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_period,
  input  logic             cmd_continuous,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             abort,
  output logic [2:0]       tmr_address,
  output logic             tmr_chipselect,
  output logic             tmr_write_n,
  output logic [15:0]      tmr_writedata,
  input  logic             tmr_irq,
  output logic             tick,
  output logic [CNT_W-1:0] tick_count,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [3:0]       dbg_state
);

  // Handshake: a command transfers on a rising clk edge where
  // cmd_valid && cmd_ready; cmd_ready is high only in IDLE, so the command
  // fields are sampled exactly once per command and ignored while busy.

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_STOP     = 4'd1,
    S_WR_PL    = 4'd2,
    S_WR_PH    = 4'd3,
    S_CLR      = 4'd4,
    S_START    = 4'd5,
    S_WAIT     = 4'd6,
    S_ACK      = 4'd7,
    S_FIN_STOP = 4'd8,
    S_FIN_CLR  = 4'd9
  } state_t;

  localparam logic [2:0]  A_STATUS   = 3'd0;
  localparam logic [2:0]  A_CONTROL  = 3'd1;
  localparam logic [2:0]  A_PERIOD_L = 3'd2;
  localparam logic [2:0]  A_PERIOD_H = 3'd3;
  localparam logic [15:0] CTL_STOP   = 16'h0008;
  localparam logic [15:0] CTL_ONE    = 16'h0005;
  localparam logic [15:0] CTL_CONT   = 16'h0007;

  state_t           state;
  state_t           state_nxt;
  logic [31:0]      period_q;
  logic             cont_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] tick_inc;
  logic             accept;
  logic             abort_hit;
  logic             abortable;

  assign accept    = (state == S_IDLE) && cmd_valid;
  assign tick_inc  = tick_count + 1'b1;
  assign abortable = (state == S_STOP) || (state == S_WR_PL) || (state == S_WR_PH) ||
                     (state == S_CLR)  || (state == S_START) || (state == S_WAIT)  ||
                     (state == S_ACK);
  assign abort_hit = abortable && abort;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Abort overrides whatever the state would otherwise do, but the current
  // cycle's write (and an ACK's tick) has already happened by then.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (cmd_valid) state_nxt = S_STOP;
      S_STOP:     state_nxt = S_WR_PL;
      S_WR_PL:    state_nxt = S_WR_PH;
      S_WR_PH:    state_nxt = S_CLR;
      S_CLR:      state_nxt = S_START;
      S_START:    state_nxt = S_WAIT;
      S_WAIT:     if (tmr_irq) state_nxt = S_ACK;
      S_ACK: begin
        if (!cont_q || ((count_q != '0) && (tick_inc == count_q))) begin
          state_nxt = S_FIN_STOP;
        end else begin
          state_nxt = S_WAIT;
        end
      end
      S_FIN_STOP: state_nxt = S_FIN_CLR;
      S_FIN_CLR:  state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
    if (abort_hit) begin
      state_nxt = S_FIN_STOP;
    end
  end

  // Bus and status outputs are a pure decode of the state register.
  always_comb begin
    tmr_chipselect = 1'b0;
    tmr_write_n    = 1'b1;
    tmr_address    = 3'd0;
    tmr_writedata  = 16'h0000;
    tick           = 1'b0;
    case (state)
      S_STOP: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = A_CONTROL;
        tmr_writedata  = CTL_STOP;
      end
      S_WR_PL: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = A_PERIOD_L;
        tmr_writedata  = period_q[15:0];
      end
      S_WR_PH: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = A_PERIOD_H;
        tmr_writedata  = period_q[31:16];
      end
      S_CLR: begin
        // Spacer write: lets the period write's force_reload expire before START.
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = A_STATUS;
      end
      S_START: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = A_CONTROL;
        tmr_writedata  = cont_q ? CTL_CONT : CTL_ONE;
      end
      S_ACK: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = A_STATUS;
        tick           = 1'b1;
      end
      S_FIN_STOP: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = A_CONTROL;
        tmr_writedata  = CTL_STOP;
      end
      S_FIN_CLR: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = A_STATUS;
      end
      default: begin
        tmr_chipselect = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_q <= 32'd0;
      cont_q   <= 1'b0;
      count_q  <= '0;
    end else if (accept) begin
      period_q <= cmd_period;
      cont_q   <= cmd_continuous;
      count_q  <= cmd_count;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_count <= '0;
      aborted    <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= (state == S_FIN_CLR);
      if (accept) begin
        tick_count <= '0;
        aborted    <= 1'b0;
      end else begin
        if (state == S_ACK) begin
          tick_count <= tick_inc;
        end
        if (abort_hit) begin
          aborted <= 1'b1;
        end
      end
    end
  end

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_timer_sequencer.sv
// Bench for timer_sequencer: interval-timer model on the bus, a write
// scoreboard fed by commands, and directed scenarios for ticks and abort.
module tb_timer_sequencer;

  localparam int CNT_W = 16;
  localparam logic [3:0] ST_FIN_STOP = 4'd8;

  logic             clk;
  logic             reset_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [31:0]      cmd_period;
  logic             cmd_continuous;
  logic [CNT_W-1:0] cmd_count;
  logic             abort;
  logic [2:0]       tmr_address;
  logic             tmr_chipselect;
  logic             tmr_write_n;
  logic [15:0]      tmr_writedata;
  logic             tmr_irq;
  logic             tick;
  logic [CNT_W-1:0] tick_count;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [3:0]       dbg_state;

  timer_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_period(cmd_period),
    .cmd_continuous(cmd_continuous), .cmd_count(cmd_count), .abort(abort),
    .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
    .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata), .tmr_irq(tmr_irq),
    .tick(tick), .tick_count(tick_count), .busy(busy), .done(done),
    .aborted(aborted), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- interval timer model ----------------
  logic [15:0] m_pl, m_ph;
  logic [31:0] m_cnt;
  logic        m_ito, m_cont, m_run, m_to;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pl <= 16'd0; m_ph <= 16'd0; m_cnt <= 32'd0;
      m_ito <= 1'b0; m_cont <= 1'b0; m_run <= 1'b0; m_to <= 1'b0;
    end else begin
      if (m_run) begin
        if (m_cnt == 32'd0) begin
          m_to  <= 1'b1;
          m_cnt <= {m_ph, m_pl};
          if (!m_cont) m_run <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 32'd1;
        end
      end
      if (tmr_chipselect && !tmr_write_n) begin
        case (tmr_address)
          3'd0: m_to <= 1'b0;
          3'd1: begin
            m_ito  <= tmr_writedata[0];
            m_cont <= tmr_writedata[1];
            if (tmr_writedata[2]) m_run <= 1'b1;
            if (tmr_writedata[3]) m_run <= 1'b0;
          end
          3'd2: begin m_pl <= tmr_writedata; m_cnt <= {m_ph, tmr_writedata}; end
          3'd3: begin m_ph <= tmr_writedata; m_cnt <= {tmr_writedata, m_pl}; end
          default: ;
        endcase
      end
    end
  end
  assign tmr_irq = m_to && m_ito;

  // ---------------- scoreboard ----------------
  int n_cmp, n_err;
  logic [18:0] exp_q[$];
  int n_ticks;
  int tick_cyc[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Every non-ACK write must match the next expected (addr,data); ACK writes
  // are identified by the tick and must be a status clear.
  always @(negedge clk) begin
    if (reset_n) begin
      if (tick) begin
        check("ack_wr", {11'd0, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata},
              {11'd0, 1'b1, 1'b0, 3'd0, 16'h0000});
        n_ticks++;
        tick_cyc.push_back(cyc);
      end else if (tmr_chipselect && !tmr_write_n) begin
        if (exp_q.size() == 0) begin
          check("bus_unexpected", {13'd0, tmr_address, tmr_writedata}, 32'hFFFF_FFFF);
        end else begin
          check("bus_wr", {13'd0, tmr_address, tmr_writedata}, {13'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic [31:0] per, input logic cont, input logic [CNT_W-1:0] cnt);
    int w;
    w = 0;
    while (!cmd_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) begin
      check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
      return;
    end
    n_ticks = 0;
    tick_cyc.delete();
    exp_q.push_back({3'd1, 16'h0008});
    exp_q.push_back({3'd2, per[15:0]});
    exp_q.push_back({3'd3, per[31:16]});
    exp_q.push_back({3'd0, 16'h0000});
    exp_q.push_back({3'd1, cont ? 16'h0007 : 16'h0005});
    exp_q.push_back({3'd1, 16'h0008});
    exp_q.push_back({3'd0, 16'h0000});
    cmd_valid = 1'b1;
    cmd_period = per;
    cmd_continuous = cont;
    cmd_count = cnt;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_period = 32'($urandom);
    cmd_continuous = 1'($urandom_range(0, 1));
    cmd_count = CNT_W'($urandom);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) break;
    end
    if (i >= budget) check({tag, "_done_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cs"},    32'(tmr_chipselect), 32'd0);
    check({tag, "_wrn"},   32'(tmr_write_n), 32'd1);
    check({tag, "_addr"},  32'(tmr_address), 32'd0);
    check({tag, "_data"},  32'(tmr_writedata), 32'd0);
    check({tag, "_tick"},  32'(tick), 32'd0);
    check({tag, "_tcnt"},  32'(tick_count), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_abrt"},  32'(aborted), 32'd0);
    check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int w;
    n_cmp = 0; n_err = 0; n_ticks = 0; cyc = 0;
    cmd_valid = 1'b0; cmd_period = 32'd0; cmd_continuous = 1'b0; cmd_count = '0;
    abort = 1'b0;
    reset_n = 1'b0;
    #1;
    check_idle_outputs("rst");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // one-shot, period 9
    send_cmd(32'd9, 1'b0, 16'd0);
    wait_done("t1", 100);
    check("t1_ticks", 32'(n_ticks), 32'd1);
    check("t1_tcnt", 32'(tick_count), 32'd1);
    check("t1_abrt", 32'(aborted), 32'd0);
    check("t1_q", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("t1_done_pulse", 32'(done), 32'd0);

    // continuous, period 4, count 3: ticks 5 cycles apart
    send_cmd(32'd4, 1'b1, 16'd3);
    wait_done("t2", 200);
    check("t2_ticks", 32'(n_ticks), 32'd3);
    check("t2_tcnt", 32'(tick_count), 32'd3);
    if (tick_cyc.size() == 3) begin
      check("t2_gap1", 32'(tick_cyc[1] - tick_cyc[0]), 32'd5);
      check("t2_gap2", 32'(tick_cyc[2] - tick_cyc[1]), 32'd5);
    end
    check("t2_tmr_run", 32'(m_run), 32'd0);
    check("t2_tmr_irq", 32'(tmr_irq), 32'd0);
    check("t2_q", 32'(exp_q.size()), 32'd0);

    // continuous unlimited, long period, then abort
    send_cmd(32'h0001_0000, 1'b1, 16'd0);
    repeat (70000) @(negedge clk);
    check("t3_busy", 32'(busy), 32'd1);
    check("t3_ticks_ge1", 32'(n_ticks >= 1), 32'd1);
    abort = 1'b1;
    wait_done("t3", 50);
    abort = 1'b0;
    check("t3_abrt", 32'(aborted), 32'd1);
    check("t3_tcnt", 32'(tick_count), 32'(n_ticks));
    check("t3_tmr_run", 32'(m_run), 32'd0);
    check("t3_q", 32'(exp_q.size()), 32'd0);

    // abort in the same cycle the IRQ rises in WAIT: no tick
    @(negedge clk);
    send_cmd(32'd4, 1'b1, 16'd0);
    w = 0;
    while (!tmr_irq && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("t4_irq_seen", 32'(tmr_irq), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    check("t4_fin_stop", 32'(dbg_state), 32'(ST_FIN_STOP));
    wait_done("t4", 20);
    abort = 1'b0;
    check("t4_ticks", 32'(n_ticks), 32'd0);
    check("t4_tcnt", 32'(tick_count), 32'd0);
    check("t4_abrt", 32'(aborted), 32'd1);
    check("t4_tmr_irq", 32'(tmr_irq), 32'd0);

    // next command right after done clears status; cmd_valid while busy ignored
    @(negedge clk);
    send_cmd(32'd4, 1'b1, 16'd2);
    check("t5_tcnt_clr", 32'(tick_count), 32'd0);
    check("t5_abrt_clr", 32'(aborted), 32'd0);
    cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t5_ready_busy", 32'(cmd_ready), 32'd0);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    wait_done("t5", 200);
    check("t5_ticks", 32'(n_ticks), 32'd2);
    check("t5_tcnt", 32'(tick_count), 32'd2);
    check("t5_q", 32'(exp_q.size()), 32'd0);

    // reset asserted during WR_PH
    @(negedge clk);
    send_cmd(32'h0003_0007, 1'b0, 16'd0);
    @(negedge clk);
    @(negedge clk);
    check("t6_in_wr_ph", {13'd0, tmr_address, tmr_writedata}, {13'd0, 3'd3, 16'h0003});
    #2 reset_n = 1'b0;
    #1;
    check_idle_outputs("t6");
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    send_cmd(32'd3, 1'b0, 16'd0);
    check("t6_restart_stop", {13'd0, tmr_address, tmr_writedata}, {13'd0, 3'd1, 16'h0008});
    wait_done("t7", 100);
    check("t7_ticks", 32'(n_ticks), 32'd1);
    check("t7_tcnt", 32'(tick_count), 32'd1);
    check("t7_q", 32'(exp_q.size()), 32'd0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/timer_sequencer.md
Name: timer_sequencer

Overview:
- Avalon-MM master that sequences one interval-timer peripheral (16-bit register map: 0 status, 1 control, 2 period_l, 3 period_h) for the Nios theremin subsystem.
- Accepts a timing command (32-bit period, one-shot or continuous, tick count) over a valid/ready handshake.
- Programs and starts the timer, acknowledges each timer IRQ, and emits one-cycle tick pulses.
- Stops and cleans up the timer on completion or on abort, leaving it quiescent with its IRQ deasserted.

Parameters:
- CNT_W, 16, width of cmd_count and tick_count.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid && cmd_ready.
- cmd_period  in  32  value loaded into period_h:period_l.
- cmd_continuous  in  1  1 = continuous mode, 0 = one-shot.
- cmd_count  in  CNT_W  number of ticks in continuous mode; 0 = unlimited.
- abort  in  1  level; requests early termination.
- tmr_address  out  3  timer register address.
- tmr_chipselect  out  1  timer select.
- tmr_write_n  out  1  active-low write strobe.
- tmr_writedata  out  16  timer write data.
- tmr_irq  in  1  timer interrupt.
- tick  out  1  one-cycle pulse per acknowledged timeout.
- tick_count  out  CNT_W  ticks delivered in the current command.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse on return to IDLE.
- aborted  out  1  sticky; 1 if the last command ended by abort.

Behaviour:
- Reset: state=IDLE, tmr_chipselect=0, tmr_write_n=1, tmr_address=0, tmr_writedata=0, tick=0, tick_count=0, busy=0, done=0, aborted=0, cmd_ready=1. Reset mid-operation returns to IDLE immediately; the bus is released and no cleanup writes are issued.
- Command capture: cmd_period, cmd_continuous and cmd_count are latched at acceptance. Inputs are ignored while busy.
- Bus outputs are Moore-decoded from the state register. Every write takes exactly one cycle (no waitrequest). Outside write states: chipselect=0, write_n=1.
- Write states, in order after acceptance, one cycle each:
  - STOP: addr1, data 0x0008.
  - WR_PL: addr2, period[15:0].
  - WR_PH: addr3, period[31:16].
  - CLR: addr0, data 0.
  - START: addr1, data 0x0005 (one-shot) or 0x0007 (continuous).
  - START then goes to WAIT.
- Ordering rule: CLR sits between WR_PH and START so the timer's force_reload pulse has expired before the start strobe.
- On acceptance, tick_count is cleared to 0 and aborted is cleared.
- WAIT: no bus activity. When tmr_irq=1, go to ACK.
- ACK: addr0 write, data 0 (clears timeout). tick=1 this cycle; tick_count increments (wraps modulo 2^CNT_W). Next state:
  - one-shot → FIN_STOP;
  - continuous and cmd_count!=0 and tick_count+1==cmd_count → FIN_STOP;
  - otherwise → WAIT.
- No double count: the IRQ is deasserted on the cycle after ACK, so WAIT never re-sees the same timeout.
- FIN_STOP: addr1, data 0x0008 (stop, ITO off). Then FIN_CLR: addr0, data 0. Then IDLE, with done=1 for the first IDLE cycle.
- Abort, sampled in STOP..ACK: the current cycle's write completes, then the next state is FIN_STOP and aborted is set.
  - abort and tmr_irq together in WAIT: abort wins; no ACK, no tick.
  - abort during ACK: that tick is still emitted.
  - abort in FIN_STOP, FIN_CLR or IDLE: ignored.
- Timing: START is the 5th cycle after the acceptance edge. With the counter reloading at zero, the tick period in continuous mode is cmd_period+1 clocks.

Test Plan:
- One-shot, period=9 → bus writes (1,0x0008),(2,9),(3,0),(0,0),(1,0x0005); exactly one tick; then (1,0x0008),(0,0); done pulse; tick_count=1; aborted=0.
- Continuous, period=4, count=3, against the timer model → 3 ticks spaced 5 cycles apart, then the FIN_STOP/FIN_CLR writes; done; tick_count=3; timer counter_is_running=0 and irq=0.
- Continuous, count=0, period=0x0001_0000 → writes (2,0),(3,1); ticks continue past 70000 cycles; abort → FIN_STOP, done, aborted=1.
- Abort asserted in the same cycle tmr_irq rises in WAIT → no tick; FIN_STOP next; tick_count unchanged.
- cmd_valid held while busy → ignored, cmd_ready=0. A second command one cycle after done is accepted, and tick_count and aborted are cleared.
- reset_n pulsed low during WR_PH → all outputs at reset values asynchronously; the next command runs the full sequence from STOP.
